// File: rtl/bram_sd_sync.sv
// Backup-RAM <-> SD-image sector transfer controller for the save-slot path.
// Streams a 2^SEC_W-sector slot through the HPS sector buffer on load/save,
// writes a default header on format, tracks a dirty flag and runs autosave.
module bram_sd_sync #(
  parameter int                    SEC_W        = 4,
  parameter int                    SLOT_W       = 2,
  parameter int                    DW           = 16,
  parameter int                    BUF_AW       = 8,
  parameter int                    FMT_WORDS    = 4,
  parameter logic [FMT_WORDS*DW-1:0] FMT_PATTERN = 64'h8010_8800_4D42_5548,
  parameter logic [23:0]           AUTOSAVE_DLY = 24'd5_000_000
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic                    bk_ena,
  input  logic                    load_req,
  input  logic                    save_req,
  input  logic                    format_req,
  input  logic                    autosave_en,
  input  logic [SLOT_W-1:0]       slot,
  input  logic                    bram_wr,
  output logic [31:0]             sd_lba,
  output logic                    sd_rd,
  output logic                    sd_wr,
  input  logic                    sd_ack,
  input  logic [BUF_AW-1:0]       sd_buff_addr,
  input  logic [DW-1:0]           sd_buff_dout,
  input  logic                    sd_buff_wr,
  output logic [SEC_W+BUF_AW-1:0] ram_addr,
  output logic [DW-1:0]           ram_din,
  output logic                    ram_we,
  output logic                    busy,
  output logic                    loading,
  output logic                    dirty
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACK  = 2'd2,
    ST_FMT  = 2'd3
  } state_t;

  state_t              state_r, state_nx_s;
  logic                load_q_r, save_q_r, fmt_q_r, ack_q_r, ack_qq_r;
  logic                load_rise_s, save_rise_s, fmt_rise_s, ack_rise_s, ack_fall_s;
  logic [SEC_W-1:0]    idx_r;
  logic [SLOT_W-1:0]   slot_r;
  logic                dir_r;
  logic [BUF_AW-1:0]   fmt_cnt_r;
  logic [23:0]         timer_r;
  logic                dirty_r, sd_rd_r, sd_wr_r;
  logic [31:0]         sd_lba_r;
  logic                start_s, start_dir_s, ack_seen_s, next_sec_s;
  logic                load_done_s, fmt_done_s, auto_ok_s, idx_last_s;

  assign load_rise_s = load_req & ~load_q_r;
  assign save_rise_s = save_req & ~save_q_r;
  assign fmt_rise_s  = format_req & ~fmt_q_r;
  // sd_ack is registered once before edge detection, so its edges act one cycle later
  assign ack_rise_s  = ack_q_r & ~ack_qq_r;
  assign ack_fall_s  = ~ack_q_r & ack_qq_r;
  assign idx_last_s  = (idx_r == {SEC_W{1'b1}});
  assign auto_ok_s   = (timer_r == 24'd0) & dirty_r & autosave_en & bk_ena;

  // Edge-detector history; reset loads current levels so no edge appears out of reset
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      load_q_r <= load_req;
      save_q_r <= save_req;
      fmt_q_r  <= format_req;
      ack_q_r  <= sd_ack;
      ack_qq_r <= sd_ack;
    end else begin
      load_q_r <= load_req;
      save_q_r <= save_req;
      fmt_q_r  <= format_req;
      ack_q_r  <= sd_ack;
      ack_qq_r <= ack_q_r;
    end
  end

  // Controller state register
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state and transfer strobes; IDLE priority is format > load > save > autosave
  always_comb begin
    state_nx_s  = state_r;
    start_s     = 1'b0;
    start_dir_s = 1'b0;
    ack_seen_s  = 1'b0;
    next_sec_s  = 1'b0;
    load_done_s = 1'b0;
    fmt_done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (fmt_rise_s) begin
          state_nx_s = ST_FMT;
        end else if (load_rise_s && bk_ena) begin
          start_s     = 1'b1;
          start_dir_s = 1'b1;
          state_nx_s  = ST_REQ;
        end else if ((save_rise_s && bk_ena) || auto_ok_s) begin
          start_s     = 1'b1;
          start_dir_s = 1'b0;
          state_nx_s  = ST_REQ;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (ack_rise_s) begin
          ack_seen_s = 1'b1;
          state_nx_s = ST_ACK;
        end else begin
          state_nx_s = ST_REQ;
        end
      end
      ST_ACK: begin
        if (ack_fall_s && idx_last_s) begin
          load_done_s = dir_r;
          state_nx_s  = ST_IDLE;
        end else if (ack_fall_s) begin
          next_sec_s = 1'b1;
          state_nx_s = ST_REQ;
        end else begin
          state_nx_s = ST_ACK;
        end
      end
      ST_FMT: begin
        if (fmt_cnt_r == BUF_AW'(FMT_WORDS - 1)) begin
          fmt_done_s = 1'b1;
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_FMT;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Sector sequencing: index, LBA and the rd/wr request lines
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      idx_r    <= {SEC_W{1'b0}};
      slot_r   <= {SLOT_W{1'b0}};
      dir_r    <= 1'b0;
      sd_lba_r <= 32'd0;
      sd_rd_r  <= 1'b0;
      sd_wr_r  <= 1'b0;
    end else if (start_s) begin
      idx_r    <= {SEC_W{1'b0}};
      slot_r   <= slot;
      dir_r    <= start_dir_s;
      sd_lba_r <= {{(32-SLOT_W-SEC_W){1'b0}}, slot, {SEC_W{1'b0}}};
      sd_rd_r  <= start_dir_s;
      sd_wr_r  <= ~start_dir_s;
    end else if (ack_seen_s) begin
      sd_rd_r <= 1'b0;
      sd_wr_r <= 1'b0;
    end else if (next_sec_s) begin
      idx_r    <= idx_r + {{(SEC_W-1){1'b0}}, 1'b1};
      sd_lba_r <= sd_lba_r + 32'd1;
      sd_rd_r  <= dir_r;
      sd_wr_r  <= ~dir_r;
    end else begin
      idx_r <= idx_r;
    end
  end

  // Format word counter runs only while in FMT and restarts at zero on entry
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      fmt_cnt_r <= {BUF_AW{1'b0}};
    end else if (state_r == ST_FMT) begin
      fmt_cnt_r <= fmt_cnt_r + {{(BUF_AW-1){1'b0}}, 1'b1};
    end else begin
      fmt_cnt_r <= {BUF_AW{1'b0}};
    end
  end

  // Dirty flag; core writes during a load are ignored since the core is held in reset
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dirty_r <= 1'b0;
    end else if (fmt_done_s) begin
      dirty_r <= 1'b1;
    end else if (load_done_s) begin
      dirty_r <= 1'b0;
    end else if (bram_wr && !loading) begin
      dirty_r <= 1'b1;
    end else if (start_s && !start_dir_s) begin
      dirty_r <= 1'b0;
    end else begin
      dirty_r <= dirty_r;
    end
  end

  // Autosave idle timer: reload on every core write, count down to zero otherwise
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      timer_r <= AUTOSAVE_DLY;
    end else if (bram_wr) begin
      timer_r <= AUTOSAVE_DLY;
    end else if (timer_r != 24'd0) begin
      timer_r <= timer_r - 24'd1;
    end else begin
      timer_r <= timer_r;
    end
  end

  // RAM port-B steering: header words in FMT, HPS buffer writes during a load
  always_comb begin
    ram_addr = {idx_r, sd_buff_addr};
    ram_din  = sd_buff_dout;
    ram_we   = sd_buff_wr & sd_ack & dir_r & (state_r != ST_IDLE);
    if (state_r == ST_FMT) begin
      ram_addr = {{SEC_W{1'b0}}, fmt_cnt_r};
      ram_din  = FMT_PATTERN[fmt_cnt_r*DW +: DW];
      ram_we   = 1'b1;
    end else begin
      ram_we = sd_buff_wr & sd_ack & dir_r & (state_r != ST_IDLE);
    end
  end

  assign sd_lba  = sd_lba_r;
  assign sd_rd   = sd_rd_r;
  assign sd_wr   = sd_wr_r;
  assign dirty   = dirty_r;
  assign busy    = (state_r != ST_IDLE);
  assign loading = (state_r != ST_IDLE) & dir_r & (state_r != ST_FMT);

endmodule

// File: doc/bram_sd_sync.md
# bram_sd_sync

Parametrised backup-RAM ↔ SD-image transfer controller for the save-slot path. It moves a multi-sector slot between the HPS sector buffer and the core's backup RAM on load, save or autosave requests. It fills a default header on format, tracks a dirty flag, and holds the core in reset while a load is in progress. It sits between `hps_io` (sd_* signals) and port B of the backup-RAM dual-port memories.

## Interface
Parameters:
- `SEC_W`, 4: log2 of sectors per slot (16 sectors).
- `SLOT_W`, 2: slot index width (4 slots).
- `DW`, 16: sector-buffer / RAM port-B data width.
- `BUF_AW`, 8: sector-buffer word-address width.
- `FMT_WORDS`, 4: number of header words written by format (≤ 2^BUF_AW).
- `FMT_PATTERN`, 64'h8010_8800_4D42_5548: packed header; word k = bits [k*DW +: DW].
- `AUTOSAVE_DLY`, 24'd5_000_000: idle cycles after the last core write before an autosave.

Ports:
- `clk_sys` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `bk_ena` in 1: writable save image mounted.
- `load_req`, `save_req`, `format_req` in 1 each: rising-edge triggered.
- `autosave_en` in 1: enable autosave.
- `slot` in SLOT_W: slot, sampled at request acceptance.
- `bram_wr` in 1: core wrote backup RAM.
- `sd_lba` out 32: sector number.
- `sd_rd`, `sd_wr` out 1: sector request to HPS.
- `sd_ack` in 1: HPS transfer in progress.
- `sd_buff_addr` in BUF_AW, `sd_buff_dout` in DW, `sd_buff_wr` in 1: HPS buffer port.
- `ram_addr` out SEC_W+BUF_AW: RAM port-B address.
- `ram_din` out DW: RAM port-B write data.
- `ram_we` out 1: RAM port-B write strobe.
- `busy` out 1: not idle (drives LED).
- `loading` out 1: load in progress (ORed into core reset).
- `dirty` out 1: RAM differs from image.

## Operation
- States: IDLE, REQ (rd/wr high, waiting for sd_ack rise), ACK (waiting for sd_ack fall), FMT.
- Edge detectors register `load_req`, `save_req`, `format_req` and `sd_ack`.
- In IDLE, priority on a simultaneous event: format > load > save > autosave.
  - Load and save are accepted only when `bk_ena`=1. Format ignores `bk_ena`.
  - Requests arriving while not IDLE are dropped; there is no queueing.
- On load/save acceptance:
  - idx ← 0; slot_r ← slot; dir ← load.
  - `sd_lba` ← {slot_r, idx}, zero-extended.
  - `sd_rd` ← dir, `sd_wr` ← ~dir.
  - Go to REQ.
- REQ: on sd_ack rise, clear `sd_rd`/`sd_wr`, go to ACK.
- ACK, on sd_ack fall:
  - If idx is all-ones: transfer done, go to IDLE.
  - Otherwise idx+1, `sd_lba`+1, re-assert the same request, go to REQ.
- `ram_addr` = {idx, sd_buff_addr} outside FMT; {0, fmt_cnt} in FMT.
- `ram_din` = `sd_buff_dout` outside FMT; pattern word fmt_cnt in FMT.
- `ram_we` = sd_buff_wr & sd_ack & dir & (state≠IDLE), or 1 in FMT. Save-direction data leaves through the RAM's q_b externally.
- FMT:
  - fmt_cnt counts 0..FMT_WORDS-1, one word per cycle.
  - Then go to IDLE and set dirty.
- Dirty flag:
  - Set by `bram_wr` or by format completion.
  - Cleared at save acceptance; a `bram_wr` during the save sets it again.
  - Cleared at load completion; `bram_wr` during a load is ignored because the core is in reset.
- Autosave:
  - The 24-bit timer reloads to AUTOSAVE_DLY on `bram_wr` and decrements to 0 otherwise.
  - At timer=0 with dirty & autosave_en & bk_ena & IDLE, start a save of the current `slot`.
- `loading` = (state≠IDLE) & dir & ~FMT. `busy` = state≠IDLE.

## Timing
- Reset values: `sd_rd`=`sd_wr`=0, `sd_lba`=0, `busy`=`loading`=0, `dirty`=0, `ram_we`=0, state IDLE, timer=AUTOSAVE_DLY, and all edge registers ← current input levels (no spurious edges).
- Request edge visible at cycle n → `sd_rd`/`sd_wr` high at n+1.
- sd_ack rise at n → `sd_rd`/`sd_wr` low at n+2 (edge register plus update).
- sd_ack fall at n → next sector request at n+2.
- Format takes exactly FMT_WORDS cycles with `ram_we` high, then `busy` low on the next cycle.
- Reset mid-transfer: abort immediately to IDLE with outputs at reset values. An sd_ack still high after reset produces no action when it falls.
- `sd_lba` never exceeds {slot_r, all-ones}; idx does not wrap within a transfer.

## Test plan
- Load slot 2 with 16-sector ack handshakes → `sd_lba` runs 0x20..0x2F, `sd_rd` only, `loading` high throughout. RAM address {idx, buff_addr} receives the buffer data. `dirty`=0 at the end.
- Save slot 1 with one `bram_wr` mid-save → `sd_wr` only, lba 0x10..0x1F, `dirty`=1 after completion.
- Format pulse → `ram_we` at addresses 0..3 with data 0x5548, 0x4D42, 0x8800, 0x8010; `dirty`=1; no sd requests.
- Load and save edges in the same cycle with `bk_ena`=1 → load wins. With `bk_ena`=0 → no activity.
- Autosave with AUTOSAVE_DLY=100, `bram_wr` at cycles 0 and 50 → `sd_wr` asserted around cycle 152, not earlier. With `autosave_en`=0 → no save.
- `reset` asserted at sector 5 of a load → outputs return to zero the next cycle. A later sd_ack fall causes no request; a new load restarts at idx 0.
